con_event_queue: RTL

Converts the 16-bit polled SNES controller state into a queue of discrete press/release events, one event per changed button. It sits directly downstream of the SNES controller poller and consumes that block's `con_state` word, which updates at most once per 60 Hz poll. Software or the IOSS bus adapter drains the queue through a valid/ready port. A debounced "currently held" mask is also exported for level-style readers.

---
 rtl/con_event_queue.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/con_event_queue.sv
// SNES controller event queue: turns changes in the polled controller word into
// press/release events, one per changed bit, drained through a show-ahead valid/ready FIFO.
module con_event_queue #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [15:0]              con_state,
    output logic                     evt_valid,
    output logic [4:0]               evt_data,
    input  logic                     evt_ready,
    output logic [$clog2(DEPTH):0]   evt_count,
    output logic [15:0]              held,
    output logic                     overflow,
    input  logic                     ovf_clr
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic StIdle = 1'b0;
    localparam logic StScan = 1'b1;

    logic          state_q, state_d;
    logic [15:0]   snap_q, snap_d;
    logic [15:0]   pend_q, pend_d;
    logic [15:0]   nxt_q, nxt_d;
    logic [15:0]   held_q;
    logic          ovf_q, ovf_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [4:0]    mem_q [DEPTH];

    logic [3:0]    idx;
    logic          last_bit;
    logic          full;
    logic          scanning;
    logic          push;
    logic          drop;
    logic          pop;
    logic [4:0]    evt_new;

    // Lowest set bit of the pending mask selects the next event.
    always_comb begin
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (pend_q[i]) begin
                idx = 4'(i);
            end
        end
    end

    assign last_bit = (pend_q & ~(16'h0001 << idx)) == 16'h0000;
    assign evt_new  = {~nxt_q[idx], idx};
    assign scanning = (state_q == StScan);
    // Room is judged on the current count only; a same-cycle pop does not make space.
    assign full     = (count_q == CW'(DEPTH));
    assign push     = scanning && !full;
    assign drop     = scanning && full;
    assign pop      = evt_valid && evt_ready;

    always_comb begin
        state_d  = state_q;
        snap_d   = snap_q;
        pend_d   = pend_q;
        nxt_d    = nxt_q;
        ovf_d    = ovf_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);

        case (state_q)
            StIdle: begin
                if (con_state != snap_q) begin
                    pend_d  = con_state ^ snap_q;
                    nxt_d   = con_state;
                    state_d = StScan;
                end
            end
            default: begin
                pend_d[idx] = 1'b0;
                if (last_bit) begin
                    snap_d  = nxt_q;
                    state_d = StIdle;
                end
            end
        endcase

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            snap_q   <= 16'hFFFF;
            pend_q   <= 16'h0000;
            nxt_q    <= 16'hFFFF;
            held_q   <= 16'h0000;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            snap_q   <= snap_d;
            pend_q   <= pend_d;
            nxt_q    <= nxt_d;
            held_q   <= ~snap_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= evt_new;
        end
    end

    assign evt_valid = (count_q != '0);
    assign evt_data  = evt_valid ? mem_q[rd_ptr_q] : 5'h00;
    assign evt_count = count_q;
    assign held      = held_q;
    assign overflow  = ovf_q;

endmodule
